rancnet_input_buffer: RTL and testbench

- Host-side ingress stage directly upstream of the RANC 3x2 network grid.
- Buffers 30-bit spike packets written by the SoC (CSR/DMA side) in a first-word-fall-through FIFO, which the grid drains with its read-enable/empty handshake.
- Sequences the global `tick`: a host tick request is released to the grid only after the FIFO is empty and the grid reports all forwarding buffers empty for a settle window.

---
 rtl/rancnet_pkg.sv | 18 +
 rtl/rancnet_input_buffer_if.sv | 37 +++
 rtl/rancnet_fwft_fifo.sv | 58 +++++
 rtl/rancnet_input_buffer.sv | 129 ++++++++++++
 tb/tb_rancnet_input_buffer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rancnet_pkg.sv
// Shared definitions for the RANC host ingress stage: packet width,
// tick sequencer states and the error-flag bit order.
package rancnet_pkg;

  localparam int PACKET_WIDTH = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TICK  = 2'd2,
    GAP   = 2'd3
  } tick_state_t;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_BITS      = 2;

endpackage

// File: rtl/rancnet_input_buffer_if.sv
// Host/grid signal bundle for the ingress stage; master is the SoC/grid
// side, slave is the buffer itself.
interface rancnet_input_buffer_if #(
  parameter int DEPTH        = 512,
  parameter int PACKET_WIDTH = 30
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic                    wr_en;
  logic [PACKET_WIDTH-1:0] wr_data;
  logic                    full;
  logic [LEVEL_W-1:0]      level;
  logic [PACKET_WIDTH-1:0] packet_out;
  logic                    empty_out;
  logic                    ren_in;
  logic                    grid_idle;
  logic                    tick_req;
  logic                    tick;
  logic                    tick_busy;
  logic [31:0]             tick_count;
  logic                    overflow;
  logic                    underflow;
  logic                    clear_errors;

  modport master (
    output wr_en, wr_data, ren_in, grid_idle, tick_req, clear_errors,
    input  full, level, packet_out, empty_out, tick, tick_busy,
           tick_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, ren_in, grid_idle, tick_req, clear_errors,
    output full, level, packet_out, empty_out, tick, tick_busy,
           tick_count, overflow, underflow
  );

endinterface

// File: rtl/rancnet_fwft_fifo.sv
// First-word-fall-through FIFO; pointers carry an extra wrap bit so full
// and empty are distinguished without a separate counter.
module rancnet_fwft_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             do_rd, do_wr;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // A write while full is only safe when the head slot is freed this cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_wr) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (do_rd) rd_ptr_next = rd_ptr_reg + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rancnet_input_buffer.sv
// Host ingress stage for the RANC grid: packet FIFO, sticky error flags and
// the sequencer that releases a tick only once the grid has gone quiet.
module rancnet_input_buffer
  import rancnet_pkg::*;
#(
  parameter int DEPTH         = 512,
  parameter int SETTLE_CYCLES = 4,
  parameter int TICK_GAP      = 8
) (
  input logic                  clk,
  input logic                  reset,
  rancnet_input_buffer_if.slave bus
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [7:0] GAP_LAST    = 8'(TICK_GAP);

  logic                    fifo_full, fifo_empty;
  logic [LEVEL_W-1:0]      fifo_level;
  logic [PACKET_WIDTH-1:0] fifo_head;

  rancnet_fwft_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (bus.ren_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bus.full       = fifo_full;
  assign bus.empty_out  = fifo_empty;
  assign bus.level      = fifo_level;
  assign bus.packet_out = fifo_head;

  // Sticky error flags; a fresh event outranks a same-cycle clear.
  logic [ERR_BITS-1:0] err_evt;
  logic [ERR_BITS-1:0] err_flags_reg;

  assign err_evt[ERR_OVERFLOW]  = bus.wr_en && fifo_full && !(bus.ren_in && !fifo_empty);
  assign err_evt[ERR_UNDERFLOW] = bus.ren_in && fifo_empty;

  generate
    for (genvar gi = 0; gi < ERR_BITS; gi++) begin : g_err
      always_ff @(posedge clk) begin
        if (reset) err_flags_reg[gi] <= 1'b0;
        else       err_flags_reg[gi] <= err_evt[gi] | (err_flags_reg[gi] & ~bus.clear_errors);
      end
    end
  endgenerate

  assign bus.overflow  = err_flags_reg[ERR_OVERFLOW];
  assign bus.underflow = err_flags_reg[ERR_UNDERFLOW];

  tick_state_t state_reg, state_next;
  logic [7:0]  settle_reg, settle_next;
  logic [7:0]  gap_reg, gap_next;
  logic        pending_reg, pending_next;
  logic [31:0] tick_count_reg, tick_count_next;
  logic        quiet;

  // Any host write counts as activity, even one the FIFO will absorb.
  assign quiet = fifo_empty && bus.grid_idle && !bus.wr_en;

  always_comb begin
    state_next      = state_reg;
    settle_next     = settle_reg;
    gap_next        = gap_reg;
    pending_next    = pending_reg;
    tick_count_next = tick_count_reg;

    if (bus.tick_req && (state_reg != IDLE)) pending_next = 1'b1;

    unique case (state_reg)
      IDLE: begin
        if (bus.tick_req || pending_reg) begin
          state_next   = DRAIN;
          pending_next = 1'b0;
          settle_next  = '0;
        end
      end
      DRAIN: begin
        if (quiet) begin
          settle_next = settle_reg + 8'd1;
          if (settle_next == SETTLE_LAST) state_next = TICK;
        end else begin
          settle_next = '0;
        end
      end
      TICK: begin
        tick_count_next = tick_count_reg + 32'd1;
        gap_next        = '0;
        state_next      = GAP;
      end
      GAP: begin
        gap_next = gap_reg + 8'd1;
        if (gap_next == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      settle_reg     <= '0;
      gap_reg        <= '0;
      pending_reg    <= 1'b0;
      tick_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      settle_reg     <= settle_next;
      gap_reg        <= gap_next;
      pending_reg    <= pending_next;
      tick_count_reg <= tick_count_next;
    end
  end

  assign bus.tick       = (state_reg == TICK);
  assign bus.tick_busy  = (state_reg != IDLE) || pending_reg;
  assign bus.tick_count = tick_count_reg;

endmodule

// File: tb/tb_rancnet_input_buffer.sv
// Directed scoreboard bench for rancnet_input_buffer: FIFO ordering, full and
// empty corner cases, sticky flags and tick sequencing.
module tb_rancnet_input_buffer;
  import rancnet_pkg::*;

  localparam int DEPTH  = 512;
  localparam int SETTLE = 4;
  localparam int GAP    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rancnet_input_buffer_if #(.DEPTH(DEPTH), .PACKET_WIDTH(PACKET_WIDTH)) bus ();

  rancnet_input_buffer #(
    .DEPTH         (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .TICK_GAP      (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [PACKET_WIDTH-1:0] sb[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  int cyc = 0, n_ticks = 0, last_tick_cyc = 0, tick_spacing = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.tick === 1'b1) begin
      n_ticks++;
      tick_spacing  = cyc - last_tick_cyc;
      last_tick_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, called at a negedge; returns at the next negedge.
  task automatic do_cycle(input bit wr, input logic [PACKET_WIDTH-1:0] d,
                          input bit rd, input bit clr, input bit treq);
    bit pop_ok, wr_ok;
    pop_ok = rd && (sb.size() != 0);
    wr_ok  = wr && ((sb.size() < DEPTH) || pop_ok);
    if (pop_ok) check("head", 64'(bus.packet_out), 64'(sb[0]));
    bus.wr_en = wr; bus.wr_data = d; bus.ren_in = rd;
    bus.clear_errors = clr; bus.tick_req = treq;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (wr && !wr_ok) m_ovf = 1'b1;
    if (rd && sb.size() == 0) m_unf = 1'b1;
    @(negedge clk);
    if (pop_ok) void'(sb.pop_front());
    if (wr_ok) sb.push_back(d);
    bus.wr_en = 1'b0; bus.ren_in = 1'b0; bus.clear_errors = 1'b0; bus.tick_req = 1'b0;
    $display("txn t=%0t wr=%0d data=0x%0h ren=%0d clr=%0d treq=%0d level=%0d",
             $time, wr, d, rd, clr, treq, bus.level);
  endtask

  task automatic wait_tick(input int limit, output int k, output bit seen);
    seen = 1'b0; k = 0;
    for (int i = 0; i <= limit; i++) begin
      if (bus.tick === 1'b1) begin seen = 1'b1; k = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_not_busy(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (bus.tick_busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(m_ovf));
    check({tag, "_unf"}, 64'(bus.underflow), 64'(m_unf));
  endtask

  initial begin
    int k, ticks0;
    bit seen, ok;

    reset = 1'b1;
    bus.wr_en = 0; bus.wr_data = '0; bus.ren_in = 0; bus.grid_idle = 1'b1;
    bus.tick_req = 0; bus.clear_errors = 0;
    repeat (3) @(negedge clk);
    check("rst_empty", 64'(bus.empty_out), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_pkt", 64'(bus.packet_out), 64'd0);
    check("rst_tick", 64'(bus.tick), 64'd0);
    check("rst_busy", 64'(bus.tick_busy), 64'd0);
    check("rst_tcount", 64'(bus.tick_count), 64'd0);
    check_flags("rst");
    reset = 1'b0;
    @(negedge clk);

    // Ordering: three writes, then three pops.
    do_cycle(1, 30'h1, 0, 0, 0);
    check("empty_after_wr", 64'(bus.empty_out), 64'd0);
    check("head_after_wr", 64'(bus.packet_out), 64'h1);
    do_cycle(1, 30'h2, 0, 0, 0);
    do_cycle(1, 30'h3, 0, 0, 0);
    check("level3", 64'(bus.level), 64'd3);
    for (int i = 2; i >= 0; i--) begin
      do_cycle(0, '0, 1, 0, 0);
      check("level_pop", 64'(bus.level), 64'(i));
    end
    check("empty_after_pops", 64'(bus.empty_out), 64'd1);

    // Simultaneous write and pop keeps the level.
    do_cycle(1, 30'h4, 0, 0, 0);
    do_cycle(1, 30'h5, 1, 0, 0);
    check("level_wr_rd", 64'(bus.level), 64'd1);
    do_cycle(0, '0, 1, 0, 0);

    // Fill to DEPTH, then overflow corner cases.
    for (int i = 0; i < DEPTH; i++) do_cycle(1, PACKET_WIDTH'($urandom), 0, 0, 0);
    check("full_set", 64'(bus.full), 64'd1);
    check("level_full", 64'(bus.level), 64'(DEPTH));
    do_cycle(1, 30'h3FFF_FFFF, 0, 0, 0);
    check("level_drop", 64'(bus.level), 64'(DEPTH));
    check_flags("ovf");
    do_cycle(0, '0, 0, 1, 0);
    check_flags("clr");
    do_cycle(1, 30'h3FFF_FFFF, 1, 0, 0);
    check("level_full_wr_rd", 64'(bus.level), 64'(DEPTH));
    check("full_still", 64'(bus.full), 64'd1);
    check_flags("full_wr_rd");
    for (int i = 0; i < DEPTH; i++) do_cycle(0, '0, 1, 0, 0);
    check("empty_after_drain", 64'(bus.empty_out), 64'd1);

    // Underflow, same-cycle write still accepted, error beats clear.
    do_cycle(1, 30'h2A, 1, 0, 0);
    check("level_unf_wr", 64'(bus.level), 64'd1);
    check_flags("unf");
    do_cycle(0, '0, 1, 0, 0);
    do_cycle(0, '0, 1, 1, 0);
    check_flags("unf_clr_race");
    do_cycle(0, '0, 0, 1, 0);
    check_flags("unf_clr");

    // Tick waits for the FIFO to drain, then SETTLE quiet cycles.
    ticks0 = n_ticks;
    do_cycle(1, 30'h11, 0, 0, 0);
    do_cycle(1, 30'h12, 0, 0, 1);
    repeat (10) @(negedge clk);
    check("no_tick_while_queued", 64'(n_ticks), 64'(ticks0));
    check("busy_drain", 64'(bus.tick_busy), 64'd1);
    do_cycle(0, '0, 1, 0, 0);
    do_cycle(0, '0, 1, 0, 0);
    wait_tick(40, k, seen);
    check("tick1_seen", 64'(seen), 64'd1);
    check("tick1_delay", 64'(k), 64'(SETTLE));
    @(negedge clk);
    check("tcount1", 64'(bus.tick_count), 64'd1);

    // Losing grid_idle at settle count 3 restarts the window.
    wait_not_busy(40, ok);
    check("idle_before_t2", 64'(ok), 64'd1);
    ticks0 = n_ticks;
    do_cycle(0, '0, 0, 0, 1);
    repeat (3) @(negedge clk);
    bus.grid_idle = 1'b0;
    @(negedge clk);
    bus.grid_idle = 1'b1;
    wait_tick(40, k, seen);
    check("tick2_seen", 64'(seen), 64'd1);
    check("tick2_delay", 64'(k), 64'(SETTLE));
    check("tick2_single", 64'(n_ticks), 64'(ticks0 + 1));

    // Three requests during GAP merge into one extra tick.
    ticks0 = n_ticks;
    @(negedge clk);
    check("busy_gap", 64'(bus.tick_busy), 64'd1);
    for (int p = 0; p < 3; p++) begin
      bus.tick_req = 1'b1;
      @(negedge clk);
      bus.tick_req = 1'b0;
      @(negedge clk);
    end
    wait_tick(60, k, seen);
    check("tick3_seen", 64'(seen), 64'd1);
    check("tick3_spacing", 64'(tick_spacing), 64'(GAP + SETTLE + 2));
    repeat (40) @(negedge clk);
    check("merged_ticks", 64'(n_ticks), 64'(ticks0 + 1));
    check("tcount3", 64'(bus.tick_count), 64'd3);
    check("busy_done", 64'(bus.tick_busy), 64'd0);

    // Reset mid-operation discards packets and the pending tick.
    do_cycle(1, 30'h21, 0, 0, 0);
    do_cycle(1, 30'h22, 0, 0, 1);
    do_cycle(0, '0, 0, 0, 1);
    check("busy_pre_rst", 64'(bus.tick_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check("mrst_empty", 64'(bus.empty_out), 64'd1);
    check("mrst_level", 64'(bus.level), 64'd0);
    check("mrst_pkt", 64'(bus.packet_out), 64'd0);
    check("mrst_busy", 64'(bus.tick_busy), 64'd0);
    check("mrst_tcount", 64'(bus.tick_count), 64'd0);
    reset = 1'b0;
    ticks0 = n_ticks;
    repeat (20) @(negedge clk);
    check("mrst_no_tick", 64'(n_ticks), 64'(ticks0));
    do_cycle(1, 30'h155, 0, 0, 0);
    do_cycle(0, '0, 1, 0, 0);
    check("mrst_reuse_empty", 64'(bus.empty_out), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
